// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter that lends one CW-bit up-counter to NREQ requesters for len+1 cycles each.
// Define ARB_FIXED_PRIORITY_EN to replace round-robin with fixed priority (req[0] highest).
module counter_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [CW-1:0]      count,
    output logic [NREQ-1:0]    done
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q,  busy_d;
    logic [CW-1:0]     count_q, count_d;
    logic [NREQ-1:0]   done_q,  done_d;
    logic [CW-1:0]     term_q,  term_d;
    logic [IW-1:0]     gidx_q,  gidx_d;

    logic              pick_found_c;
    logic [IW-1:0]     pick_idx_c;
    logic [CW-1:0]     pick_len_c;

`ifdef ARB_FIXED_PRIORITY_EN
    // Lowest-index requester always wins.
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!pick_found_c && req[IW'(k)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    int unsigned       scan_idx;

    // First set request scanning upward from rr_ptr, wrapping at NREQ.
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        scan_idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!pick_found_c && req[IW'(scan_idx)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IW'(scan_idx);
            end
        end
    end
`endif

    always_comb begin
        pick_len_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick_idx_c == IW'(k)) begin
                pick_len_c = len[k*CW +: CW];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        count_d = count_q;
        done_d  = '0;
        term_d  = term_q;
        gidx_d  = gidx_q;
`ifndef ARB_FIXED_PRIORITY_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
                if (pick_found_c) begin
                    grant_d = NREQ'(1) << pick_idx_c;
                    busy_d  = 1'b1;
                    term_d  = pick_len_c;
                    gidx_d  = pick_idx_c;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!req[gidx_q] || (count_q == term_q)) begin
                    // Abort and completion both release the counter; only completion reports done.
                    if (req[gidx_q]) begin
                        done_d  = grant_q;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
`ifndef ARB_FIXED_PRIORITY_EN
                    rr_ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
`endif
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            count_q  <= '0;
            done_q   <= '0;
            term_q   <= '0;
            gidx_q   <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
            done_q   <= done_d;
            term_q   <= term_d;
            gidx_q   <= gidx_d;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign done  = done_q;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Self-checking bench for counter_share_arbiter: directed scenarios plus randomized schedules
// compared against a turn-by-turn interval model.
module tb_counter_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 4;
    localparam int unsigned VW   = 2 * NREQ + 1 + CW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [CW-1:0]      count;
    logic [NREQ-1:0]    done;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    counter_share_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .grant (grant),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Which requester the arbiter should serve next, given the requests and the fairness pointer.
    function automatic int model_pick(input logic [NREQ-1:0] mask, input int ptr);
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < int'(NREQ); i++)
            if (mask[i]) return i;
`else
        for (int k = 0; k < int'(NREQ); k++) begin
            int i;
            i = (ptr + k) % int'(NREQ);
            if (mask[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Drives held requests through 'turns' complete intervals: len+1 grant cycles, one done cycle, one idle cycle.
    task automatic run_schedule(input int turns, input bit jitter_len);
        logic [VW-1:0] exp_v;
        logic [VW-1:0] obs_v;
        int g;
        int l;
        for (int t = 0; t < turns; t++) begin
            g = model_pick(req, m_ptr);
            if (g < 0) begin
                errors++;
                $display("FAIL schedule: no requester to serve, req=%b", req);
                return;
            end
            l = int'(len[g*CW +: CW]);
            for (int c = 0; c <= l; c++) begin
                @(negedge clk);
                exp_v = {NREQ'(1) << g, 1'b1, CW'(c), NREQ'(0)};
                obs_v = {grant, busy, count, done};
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL run turn%0d req%0d cyc%0d: got g=%b b=%b c=%0d d=%b, want %h",
                             t, g, c, grant, busy, count, done, exp_v);
                end
                if (jitter_len && ($urandom_range(0, 1) == 1))
                    len[g*CW +: CW] = CW'($urandom);
            end
            @(negedge clk);
            exp_v = {NREQ'(0), 1'b0, CW'(0), NREQ'(1) << g};
            obs_v = {grant, busy, count, done};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL done turn%0d req%0d: got g=%b b=%b c=%0d d=%b, want %h",
                         t, g, grant, busy, count, done, exp_v);
            end
            @(negedge clk);
            checks++;
            if ({grant, busy, count, done} !== VW'(0)) begin
                errors++;
                $display("FAIL gap turn%0d: got g=%b b=%b c=%0d d=%b, want all zero",
                         t, grant, busy, count, done);
            end
            m_ptr = (g + 1) % int'(NREQ);
        end
    endtask

    task automatic drop_req();
        req = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({grant, busy, count, done} !== VW'(0)) begin
            errors++;
            $display("FAIL idle after drop: got g=%b b=%b c=%0d d=%b, want all zero",
                     grant, busy, count, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        len = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL reset grant: got %b want 0", grant); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++;
        if (count !== '0) begin errors++; $display("FAIL reset count: got %0d want 0", count); end
        checks++;
        if (done !== '0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single();
        len = '0;
        len[0 +: CW] = CW'(3);
        req = 4'b0001;
        run_schedule(2, 1'b0);
        drop_req();
    endtask

    task automatic test_round_robin();
        test_reset();
        for (int i = 0; i < int'(NREQ); i++) len[i*CW +: CW] = CW'(1);
        req = 4'b1111;
        run_schedule(5, 1'b0);
        drop_req();
    endtask

    task automatic test_boundaries();
        len = '0;
        req = 4'b0001;
        run_schedule(1, 1'b0);
        drop_req();
        len[1*CW +: CW] = CW'(15);
        req = 4'b0010;
        run_schedule(1, 1'b1);
        drop_req();
    endtask

    task automatic test_abort();
        bit hit;
        test_reset();
        len = '0;
        len[0*CW +: CW] = CW'(10);
        len[1*CW +: CW] = CW'(2);
        req = 4'b0011;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant == 4'b0001 && count == CW'(4)) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort setup: count 4 on requester 0 not reached, g=%b c=%0d", grant, count);
        end
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if ({grant, busy, count, done} !== VW'(0)) begin
            errors++;
            $display("FAIL abort release: got g=%b b=%b c=%0d d=%b, want all zero", grant, busy, count, done);
        end
        @(negedge clk);
        checks++;
        if ({grant, busy, count, done} !== {4'b0010, 1'b1, CW'(0), 4'b0000}) begin
            errors++;
            $display("FAIL abort regrant: got g=%b b=%b c=%0d d=%b, want g=0010 b=1 c=0 d=0",
                     grant, busy, count, done);
        end
        drop_req();
        m_ptr = 2;
    endtask

    task automatic test_reset_mid_run();
        bit hit;
        for (int i = 0; i < int'(NREQ); i++) len[i*CW +: CW] = CW'(7);
        req = 4'b1111;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && count == CW'(5)) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midrst setup: count 5 not reached, c=%0d", count);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({grant, busy, count, done} !== VW'(0)) begin
            errors++;
            $display("FAIL midrst clear: got g=%b b=%b c=%0d d=%b, want all zero", grant, busy, count, done);
        end
        rst   = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        checks++;
        if ({grant, busy, count, done} !== {4'b0001, 1'b1, CW'(0), 4'b0000}) begin
            errors++;
            $display("FAIL midrst regrant: got g=%b b=%b c=%0d d=%b, want g=0001 b=1 c=0 d=0",
                     grant, busy, count, done);
        end
        drop_req();
        m_ptr = 1;
    endtask

`ifdef ARB_FIXED_PRIORITY_EN
    task automatic test_fixed_priority();
        for (int i = 0; i < int'(NREQ); i++) len[i*CW +: CW] = CW'($urandom_range(0, 5));
        req = 4'b0110;
        run_schedule(4, 1'b0);
        drop_req();
    endtask
`endif

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < int'(NREQ); i++) len[i*CW +: CW] = CW'($urandom_range(0, 9));
            req = NREQ'($urandom_range(1, 15));
            run_schedule($urandom_range(1, 4), 1'b1);
            drop_req();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_boundaries();
        test_abort();
        test_reset_mid_run();
`ifdef ARB_FIXED_PRIORITY_EN
        test_fixed_priority();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
